// File: rtl/imu_spi_poller.sv
// SPI mode-0 master that polls six 16-bit IMU channels (gyro XYZ, then mag XYZ)
// and publishes them as a sign-extended frame, committed atomically once per poll.
module imu_spi_poller #(
  parameter int         CLK_DIV  = 4,
  parameter int         GAP      = 8,
  parameter logic [5:0] GYR_ADDR = 6'h02,
  parameter logic [5:0] MAG_ADDR = 6'h10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic [31:0] gyr_x,
  output logic [31:0] gyr_y,
  output logic [31:0] gyr_z,
  output logic [31:0] mag_x,
  output logic [31:0] mag_y,
  output logic [31:0] mag_z,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;
  localparam logic [2:0] ST_COMMIT = 3'd5;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);
  localparam logic [5:0] EDGE_LAST  = 6'd47;
  localparam logic [2:0] AXIS_LAST  = 3'd5;

  logic [2:0]  state;
  logic [2:0]  axis;
  logic [7:0]  div_cnt;
  logic [5:0]  edge_cnt;
  logic [23:0] tx_sr;
  logic [15:0] rx_sr;
  logic [15:0] shadow [6];

  // Read command for an axis: read bit, auto-increment bit, register address.
  function automatic logic [7:0] cmd_byte(input logic [2:0] ax);
    logic [5:0] addr;
    // NOTE: blocking assignments are correct for function-local temporaries;
    // all registered state below uses non-blocking assignments.
    case (ax)
      3'd0:    addr = GYR_ADDR;
      3'd1:    addr = GYR_ADDR + 6'd2;
      3'd2:    addr = GYR_ADDR + 6'd4;
      3'd3:    addr = MAG_ADDR;
      3'd4:    addr = MAG_ADDR + 6'd2;
      default: addr = MAG_ADDR + 6'd4;
    endcase
    return {2'b11, addr};
  endfunction

  function automatic logic [31:0] sext(input logic [15:0] s);
    return {{16{s[15]}}, s};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      axis        <= 3'd0;
      div_cnt     <= 8'd0;
      edge_cnt    <= 6'd0;
      tx_sr       <= 24'd0;
      rx_sr       <= 16'd0;
      spi_sclk    <= 1'b0;
      spi_mosi    <= 1'b0;
      spi_cs_n    <= 1'b1;
      gyr_x       <= 32'd0;
      gyr_y       <= 32'd0;
      gyr_z       <= 32'd0;
      mag_x       <= 32'd0;
      mag_y       <= 32'd0;
      mag_z       <= 32'd0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
      busy        <= 1'b0;
      // NOTE: the shadows are reset deliberately so an aborted poll can never
      // leak stale samples into a later frame; this is a tiny register bank.
      for (int i = 0; i < 6; i++) shadow[i] <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state    <= ST_SETUP;
            axis     <= 3'd0;
            div_cnt  <= 8'd0;
            spi_cs_n <= 1'b0;
            tx_sr    <= {cmd_byte(3'd0), 16'h0000};
            spi_mosi <= 1'b1;
            busy     <= 1'b1;
          end
        end

        ST_SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= 8'd0;
            edge_cnt <= 6'd0;
            state    <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        // Each half-period ends with an SCLK toggle: sample on the rise,
        // advance MOSI on the fall.
        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= 8'd0;
            spi_sclk <= ~spi_sclk;
            edge_cnt <= edge_cnt + 6'd1;
            if (!spi_sclk) begin
              rx_sr <= {rx_sr[14:0], spi_miso};
            end else begin
              tx_sr    <= {tx_sr[22:0], 1'b0};
              spi_mosi <= tx_sr[22];
            end
            if (edge_cnt == EDGE_LAST) begin
              state        <= ST_HOLD;
              shadow[axis] <= rx_sr;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        ST_HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= 8'd0;
            spi_cs_n <= 1'b1;
            state    <= ST_GAP;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        ST_GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= 8'd0;
            if (axis == AXIS_LAST) begin
              state      <= ST_COMMIT;
              frame_done <= 1'b1;
            end else begin
              axis     <= axis + 3'd1;
              state    <= ST_SETUP;
              spi_cs_n <= 1'b0;
              tx_sr    <= {cmd_byte(axis + 3'd1), 16'h0000};
              spi_mosi <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        // All six outputs change on the same edge so the consumer never sees
        // a mix of two polls.
        ST_COMMIT: begin
          gyr_x       <= sext(shadow[0]);
          gyr_y       <= sext(shadow[1]);
          gyr_z       <= sext(shadow[2]);
          mag_x       <= sext(shadow[3]);
          mag_y       <= sext(shadow[4]);
          mag_z       <= sext(shadow[5]);
          frame_count <= frame_count + 16'd1;
          if (enable) begin
            state    <= ST_SETUP;
            axis     <= 3'd0;
            div_cnt  <= 8'd0;
            spi_cs_n <= 1'b0;
            tx_sr    <= {cmd_byte(3'd0), 16'h0000};
            spi_mosi <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          spi_cs_n <= 1'b1;
          spi_sclk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imu_spi_poller.sv
// Directed bench for imu_spi_poller: behavioural sensor model, SPI bus monitor
// and hand-computed frame values with the default parameters.
module tb_imu_spi_poller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        spi_miso = 1'b0;
  logic        spi_sclk, spi_mosi, spi_cs_n;
  logic [31:0] gyr_x, gyr_y, gyr_z, mag_x, mag_y, mag_z;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        busy;

  imu_spi_poller dut (
    .clk(clk), .reset(reset), .enable(enable), .spi_miso(spi_miso),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .gyr_x(gyr_x), .gyr_y(gyr_y), .gyr_z(gyr_z),
    .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z),
    .frame_done(frame_done), .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sensor register contents, indexed gyr x/y/z, mag x/y/z.
  logic [15:0] sens [6] = '{16'h0123, 16'hFFFE, 16'h8000, 16'h7FFF, 16'h0000, 16'h00FF};

  logic [7:0] cmd_q [$];
  int         fd_q  [$];
  int         ncyc = 0;
  bit         abort_win = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  // Sensor model and bus monitor, evaluated away from the active edge.
  logic       prev_cs = 1'b1, prev_sclk = 1'b0;
  int         rises = 0;
  logic [7:0] s_cmd = 8'h00;
  logic [15:0] s_out = 16'h0000;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_q.push_back(ncyc);
    if (prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
      rises = 0;
      s_cmd = 8'h00;
    end
    if (spi_cs_n === 1'b0 && prev_sclk === 1'b0 && spi_sclk === 1'b1) begin
      s_cmd = {s_cmd[6:0], spi_mosi};
      rises++;
      if (rises == 8) cmd_q.push_back(s_cmd);
    end
    if (spi_cs_n === 1'b0 && prev_sclk === 1'b1 && spi_sclk === 1'b0 && rises >= 8) begin
      if (rises == 8) begin
        case (s_cmd[5:0])
          6'h02:   s_out = sens[0];
          6'h04:   s_out = sens[1];
          6'h06:   s_out = sens[2];
          6'h10:   s_out = sens[3];
          6'h12:   s_out = sens[4];
          6'h14:   s_out = sens[5];
          default: s_out = 16'hDEAD;
        endcase
      end
      spi_miso = s_out[15];
      s_out    = {s_out[14:0], 1'b0};
    end
    if (prev_cs === 1'b0 && spi_cs_n === 1'b1) begin
      check("sclk_low_at_cs_rise", 32'(spi_sclk), 32'd0);
      if (!abort_win) check("sclk_rises_per_window", rises, 24);
      abort_win = 0;
    end
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  logic [7:0] exp_cmd [6] = '{8'hC2, 8'hC4, 8'hC6, 8'hD0, 8'hD2, 8'hD4};
  int  n, n0;
  bit  changed, bad;

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_gyr_x", gyr_x, 32'd0);
    check("rst_mag_z", mag_z, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single frame from a one-cycle enable pulse.
    cmd_q.delete(); fd_q.delete();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    n = 1;
    check("cs_fall_cycle1", 32'(spi_cs_n), 32'd0);
    while (frame_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("commit_cycle", n, 1249);
    check("hold_during_commit", gyr_x, 32'd0);
    @(negedge clk);
    check("f1_gyr_x", gyr_x, 32'h0000_0123);
    check("f1_gyr_y", gyr_y, 32'hFFFF_FFFE);
    check("f1_gyr_z", gyr_z, 32'hFFFF_8000);
    check("f1_mag_x", mag_x, 32'h0000_7FFF);
    check("f1_mag_y", mag_y, 32'h0000_0000);
    check("f1_mag_z", mag_z, 32'h0000_00FF);
    check("f1_frame_count", 32'(frame_count), 32'd1);
    check("f1_busy_low", 32'(busy), 32'd0);
    repeat (50) @(negedge clk);
    check("f1_one_frame_done", fd_q.size(), 1);
    check("f1_cmd_count", cmd_q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < cmd_q.size()) check($sformatf("f1_cmd%0d", i), 32'(cmd_q[i]), 32'(exp_cmd[i]));

    // Coherency: data changes after gyr_y; enable drops during gyr_z.
    fd_q.delete();
    changed = 0;
    enable  = 1'b1;
    n = 0;
    while (frame_done !== 1'b1 && n < 3000) begin
      @(negedge clk); n++;
      if (n == 420) begin
        sens[0] = 16'h5555; sens[1] = 16'h6666; sens[2] = 16'h1234;
        sens[3] = 16'hA5A5; sens[4] = 16'h0001; sens[5] = 16'hFF00;
      end
      if (n == 500) enable = 1'b0;
      if (gyr_x !== 32'h0000_0123 || gyr_y !== 32'hFFFF_FFFE || gyr_z !== 32'hFFFF_8000 ||
          mag_x !== 32'h0000_7FFF || mag_y !== 32'h0000_0000 || mag_z !== 32'h0000_00FF)
        changed = 1;
    end
    check("f2_commit_cycle", n, 1249);
    check("f2_no_early_change", 32'(changed), 32'd0);
    @(negedge clk);
    check("f2_gyr_x_old", gyr_x, 32'h0000_0123);
    check("f2_gyr_y_old", gyr_y, 32'hFFFF_FFFE);
    check("f2_gyr_z_new", gyr_z, 32'h0000_1234);
    check("f2_mag_x_new", mag_x, 32'hFFFF_A5A5);
    check("f2_mag_y_new", mag_y, 32'h0000_0001);
    check("f2_mag_z_new", mag_z, 32'hFFFF_FF00);
    check("f2_frame_count", 32'(frame_count), 32'd2);
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (spi_cs_n !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    check("f2_idle_after_drop", 32'(bad), 32'd0);
    check("f2_one_frame_done", fd_q.size(), 1);

    // Continuous polling across the frame_count wrap.
    force dut.frame_count = 16'hFFFE;
    @(negedge clk);
    release dut.frame_count;
    fd_q.delete();
    enable = 1'b1;
    n = 0;
    while (frame_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    @(negedge clk);
    check("wrap_count_ffff", 32'(frame_count), 32'h0000_FFFF);
    n = 0;
    while (frame_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    @(negedge clk);
    check("wrap_count_0000", 32'(frame_count), 32'h0000_0000);
    check("wrap_two_done", fd_q.size(), 2);
    if (fd_q.size() >= 2) check("frame_period", fd_q[1] - fd_q[0], 1249);
    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    check("cont_stops", 32'(busy), 32'd0);

    // Reset during the mag_x shift.
    enable = 1'b1;
    repeat (700) @(negedge clk);
    check("mid_txn_cs_low", 32'(spi_cs_n), 32'd0);
    reset     = 1'b1;
    abort_win = 1;
    @(negedge clk);
    check("rst_mid_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_mid_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mid_gyr_x", gyr_x, 32'd0);
    check("rst_mid_gyr_z", gyr_z, 32'd0);
    check("rst_mid_mag_x", mag_x, 32'd0);
    check("rst_mid_frame_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    cmd_q.delete();
    reset = 1'b0;
    n = 0;
    while (cmd_q.size() == 0 && n < 300) begin @(negedge clk); n++; end
    check("post_rst_first_cmd", cmd_q.size() > 0 ? 32'(cmd_q[0]) : 32'hFFFF_FFFF, 32'h0000_00C2);
    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    check("post_rst_frame_count", 32'(frame_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imu_spi_poller.md
# imu_spi_poller

Upstream stage of the IMU Avalon slave. It runs continuously as an SPI mode-0 master and reads the six 16-bit sensor channels: gyroscope X/Y/Z, then magnetometer X/Y/Z. It sign-extends each sample to 32 bits and presents all six as a coherent frame, updated atomically once per complete poll. The Avalon slave consumes these outputs directly as its register contents.

## Interface
- CLK_DIV, 4: SCLK half-period in clk cycles; legal values 2..255.
- GAP, 8: idle clk cycles with CS high between transactions; legal values 1..255.
- GYR_ADDR, 6'h02: sensor register address of gyr_x high byte; axis n (n = 0..2) is at GYR_ADDR + 2n.
- MAG_ADDR, 6'h10: sensor register address of mag_x high byte; axis n (n = 0..2) is at MAG_ADDR + 2n.
- clk  in  1  single clock; the SPI interface is fully synchronous to it.
- reset  in  1  synchronous, active-high.
- enable  in  1  polling enable; level-sensitive.
- spi_miso  in  1  serial data from the sensor.
- spi_sclk  out  1  SPI clock; idles low.
- spi_mosi  out  1  serial command to the sensor.
- spi_cs_n  out  1  chip select, active low.
- gyr_x, gyr_y, gyr_z, mag_x, mag_y, mag_z  out  32 each  sign-extended samples.
- frame_done  out  1  one-cycle pulse when a new frame is committed.
- frame_count  out  16  count of committed frames; wraps.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Reset values (all registered outputs):
  - six data outputs = 0, frame_count = 0, frame_done = 0, busy = 0
  - spi_cs_n = 1, spi_sclk = 0, spi_mosi = 0
  - FSM enters IDLE and the axis index = 0.
- FSM states are IDLE, SETUP, SHIFT, HOLD, GAP and COMMIT.
- IDLE: when enable = 1, go to SETUP with axis index 0.
- SETUP:
  - spi_cs_n = 0; spi_mosi = command bit 23.
  - Duration is CLK_DIV cycles, then go to SHIFT.
- Transaction word is 24 bits:
  - bits [23:16] = command {1'b1 (read), 1'b1 (auto-increment), addr[5:0]}.
  - bits [15:0] = don't-care on MOSI (driven 0); MISO carries data, high byte first.
- SHIFT (SPI mode 0):
  - spi_sclk toggles every CLK_DIV cycles, for 24 rising and 24 falling edges.
  - MISO is sampled in the cycle where spi_sclk goes 0→1.
  - MOSI advances to the next bit in the cycle where spi_sclk goes 1→0.
  - After the 24th falling edge, go to HOLD.
- HOLD: spi_sclk = 0, spi_cs_n = 0 for CLK_DIV cycles, then spi_cs_n = 1 and go to GAP.
- GAP: GAP cycles with spi_cs_n = 1.
  - If axis index < 5: increment the index and go to SETUP.
  - If axis index = 5: go to COMMIT.
- The last 16 MISO bits of each transaction go into a 16-bit shadow register for that axis; the outputs are not touched during the frame.
- COMMIT (1 cycle):
  - All six outputs load {{16{s[15]}}, s} from their shadows simultaneously.
  - frame_done = 1 and frame_count increments, wrapping 16'hFFFF→0.
  - If enable = 1, go to SETUP with axis 0; otherwise go to IDLE.
- enable deasserted mid-frame: the current frame completes and commits, then the FSM goes to IDLE. A partial frame is never committed.
- reset mid-transaction (next cycle):
  - spi_cs_n = 1 and spi_sclk = 0.
  - Shadows are discarded; outputs revert to the reset values.
- Outputs hold their value between commits and in IDLE.

## Timing
- Cycle 0 is the cycle in which IDLE samples enable = 1; spi_cs_n falls at cycle 1.
- One transaction spans CLK_DIV·50 + GAP cycles from the CS falling edge to the next CS falling edge. With the defaults this is 4·50 + 8 = 208.
- COMMIT occurs 6·(50·CLK_DIV + GAP) cycles after cycle 1: cycle 1249 with the defaults.
  - frame_done is high during that cycle; outputs show the new values at cycle 1250.
- In continuous mode, frame period = 6·(50·CLK_DIV + GAP) + 1 cycles (1249 with the defaults).
- spi_sclk, spi_mosi and spi_cs_n are registered, with no combinational path from inputs.
- Setup from CS falling to the first SCLK rise is CLK_DIV cycles.
- Hold from the last SCLK fall to CS rising is CLK_DIV cycles.

## Test plan
- Single frame: sensor model returns gyr 16'h0123 / 16'hFFFE / 16'h8000 and mag 16'h7FFF / 16'h0000 / 16'h00FF; pulse enable for 1 cycle.
  - Outputs become 32'h00000123, 32'hFFFFFFFE, 32'hFFFF8000, 32'h00007FFF, 32'h0, 32'h000000FF.
  - One frame_done at cycle 1249 (default parameters); busy is low after it.
- Command check: monitor the MOSI bytes per transaction. Expected sequence is 8'hC2, C4, C6, D0, D2, D4; exactly 24 SCLK rises per CS-low window; SCLK low whenever CS rises.
- Coherency: change the model data mid-frame (after the gyr_y transaction). No output changes before COMMIT, and the committed values match the bytes actually shifted.
- Continuous and wrap: hold enable = 1 and preload frame_count to 16'hFFFE via repeated frames (or force). After 2 commits frame_count = 16'h0000; the frame_done spacing is exactly 1249 cycles.
- Reset mid-transaction: assert reset during the SHIFT of mag_x.
  - The next cycle shows spi_cs_n = 1, spi_sclk = 0, all outputs 0 and frame_count = 0.
  - After release with enable = 1, the first MOSI byte is 8'hC2.
- enable drop: deassert enable during the gyr_z transaction. The frame still commits (one frame_done), then IDLE, with spi_cs_n held at 1 for 2000 cycles.
